// File: rtl/upper_triangular_unpack.sv
// upper_triangular_unpack
// Rebuilds a full SIZE x SIZE matrix from a packed row-major stream of its
// upper triangle, then streams the full matrix out row-major.
// Build option: define SYMMETRIC_MIRROR_EN to mirror every upper-triangle write
// into the lower triangle (symmetric output). Without it the lower triangle
// stays zero.
module upper_triangular_unpack #(
   parameter int SIZE       = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_tdata,
   input  logic                  in_tvalid,
   output logic                  in_tready,
   output logic [DATA_WIDTH-1:0] out_tdata,
   input  logic                  out_tready,
   output logic                  out_tvalid,
   output logic                  out_tlast
);

   localparam int RW = $clog2(SIZE);
   localparam int EW = $clog2(SIZE*SIZE+1);
   localparam logic [RW-1:0] LAST_IDX      = RW'(SIZE-1);
   localparam logic [EW-1:0] LAST_BEAT     = EW'(SIZE*SIZE-1);
   localparam logic [EW-1:0] PRE_LAST_BEAT = EW'(SIZE*SIZE-2);

   typedef enum logic {ST_LOAD = 1'b0, ST_EMIT = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [RW-1:0]         lr_q, lr_d, lc_q, lc_d;
   logic [RW-1:0]         er_q, er_d, ec_q, ec_d;
   logic [RW-1:0]         nr, nc;
   logic [EW-1:0]         e_q, e_d;
   logic                  in_tready_q, in_tready_d;
   logic                  out_tvalid_q, out_tvalid_d;
   logic                  out_tlast_q, out_tlast_d;
   logic [DATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
   logic [DATA_WIDTH-1:0] mat_q [SIZE][SIZE];

   logic load_fire, last_load, emit_fire, last_emit;

   assign load_fire = (state_q == ST_LOAD) && in_tvalid && in_tready_q;
   assign last_load = (lr_q == LAST_IDX) && (lc_q == LAST_IDX);
   assign emit_fire = out_tvalid_q && out_tready;
   assign last_emit = (e_q == LAST_BEAT);

   assign in_tready  = in_tready_q;
   assign out_tvalid = out_tvalid_q;
   assign out_tdata  = out_tdata_q;
   assign out_tlast  = out_tlast_q;

   // Matrix storage: cleared on reset, written only while loading
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
               mat_q[r][c] <= '0;
            end
         end
      end else if (load_fire) begin
         mat_q[lr_q][lc_q] <= in_tdata;
`ifdef SYMMETRIC_MIRROR_EN
         if (lr_q != lc_q) begin
            mat_q[lc_q][lr_q] <= in_tdata;
         end
`endif
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_LOAD;
         lr_q         <= '0;
         lc_q         <= '0;
         er_q         <= '0;
         ec_q         <= '0;
         e_q          <= '0;
         in_tready_q  <= 1'b1;
         out_tvalid_q <= 1'b0;
         out_tlast_q  <= 1'b0;
         out_tdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         lr_q         <= lr_d;
         lc_q         <= lc_d;
         er_q         <= er_d;
         ec_q         <= ec_d;
         e_q          <= e_d;
         in_tready_q  <= in_tready_d;
         out_tvalid_q <= out_tvalid_d;
         out_tlast_q  <= out_tlast_d;
         out_tdata_q  <= out_tdata_d;
      end
   end

   // Next state: leave LOAD on the last packed element, leave EMIT on the tlast beat
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (load_fire && last_load) state_d = ST_EMIT;
         ST_EMIT: if (emit_fire && last_emit) state_d = ST_LOAD;
         default: state_d = ST_LOAD;
      endcase
   end

   // Counter and output next values; the next beat is pre-read from storage
   always_comb begin
      lr_d         = lr_q;
      lc_d         = lc_q;
      er_d         = er_q;
      ec_d         = ec_q;
      e_d          = e_q;
      in_tready_d  = in_tready_q;
      out_tvalid_d = out_tvalid_q;
      out_tlast_d  = out_tlast_q;
      out_tdata_d  = out_tdata_q;
      if (ec_q == LAST_IDX) begin
         nr = er_q + 1'b1;
         nc = '0;
      end else begin
         nr = er_q;
         nc = ec_q + 1'b1;
      end
      case (state_q)
         ST_LOAD: begin
            if (load_fire) begin
               if (last_load) begin
                  // Final element lands in storage on this edge; it is emitted last,
                  // so the first beat can already be read here.
                  lr_d         = '0;
                  lc_d         = '0;
                  er_d         = '0;
                  ec_d         = '0;
                  e_d          = '0;
                  in_tready_d  = 1'b0;
                  out_tvalid_d = 1'b1;
                  out_tlast_d  = 1'b0;
                  out_tdata_d  = mat_q[0][0];
               end else if (lc_q == LAST_IDX) begin
                  // Next row starts on its diagonal
                  lr_d = lr_q + 1'b1;
                  lc_d = lr_q + 1'b1;
               end else begin
                  lc_d = lc_q + 1'b1;
               end
            end
         end
         ST_EMIT: begin
            if (emit_fire) begin
               if (last_emit) begin
                  er_d         = '0;
                  ec_d         = '0;
                  e_d          = '0;
                  in_tready_d  = 1'b1;
                  out_tvalid_d = 1'b0;
                  out_tlast_d  = 1'b0;
               end else begin
                  er_d        = nr;
                  ec_d        = nc;
                  e_d         = e_q + 1'b1;
                  out_tdata_d = mat_q[nr][nc];
                  out_tlast_d = (e_q == PRE_LAST_BEAT);
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/upper_triangular_unpack.md
# upper_triangular_unpack

Downstream companion to the upper-triangle extraction stage. It accepts a packed, row-major stream of the SIZE*(SIZE+1)/2 upper-triangular elements of a SIZE x SIZE matrix and rebuilds the full SIZE*SIZE matrix. The full matrix leaves as a row-major stream. Both sides use valid/ready handshakes, so the block sits directly behind the extractor and feeds any full-matrix consumer.

## Interface
- SIZE, 4, matrix dimension (2..16)
- DATA_WIDTH, 32, element width in bits
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_tdata  in  DATA_WIDTH  packed upper-triangle element
- in_tvalid  in  1  in_tdata valid
- in_tready  out  1  block can accept an element
- out_tdata  out  DATA_WIDTH  full-matrix element, row-major
- out_tready  in  1  consumer accepts out_tdata
- out_tvalid  out  1  out_tdata valid
- out_tlast  out  1  high with the final element (row SIZE-1, col SIZE-1)

## Operation
- Storage: SIZE*SIZE register array, M[r][c]. All entries are cleared to 0 on reset.
- State machine: LOAD -> EMIT -> LOAD.
- LOAD state:
  - in_tready = 1.
  - On accept (in_tvalid && in_tready), write in_tdata to M[r][c].
  - Load counters start at r=0, c=0.
  - c increments. When c = SIZE-1: r++, c = r.
  - Accepting element (SIZE-1, SIZE-1) moves the block to EMIT and resets the load counters.
- EMIT state:
  - in_tready = 0. in_tvalid is ignored.
  - Emit counter e runs 0..SIZE*SIZE-1. out_tdata = M[e/SIZE][e%SIZE], tracked as separate row/col counters with no divider.
  - e advances on each out_tvalid && out_tready.
  - The beat with e = SIZE*SIZE-1 asserts out_tlast. Accepting it returns the block to LOAD.
- Lower-triangle entries (r > c) are never written in LOAD. Their content depends on the configuration (see Configuration).
- No overlap: matrix N+1 is not accepted until the final beat of matrix N has been taken.
- Counter widths: clog2(SIZE) for row/col, clog2(SIZE*SIZE+1) for e.

## Timing
- Reset values:
  - in_tready = 1, out_tvalid = 0, out_tdata = 0, out_tlast = 0.
  - State = LOAD. All counters = 0. M all 0.
- Reset mid-operation: any partial load or emit is discarded immediately. The next accepted element is (0,0) of a new matrix.
- All outputs are registered. in_tready is a registered function of state.
- Latency: out_tvalid rises on the clock edge that follows acceptance of the last packed element. The first output beat is therefore visible 1 cycle after the last input handshake.
- in_tready deasserts in that same cycle.
- Throughput: 1 output beat per cycle while out_tready = 1.
- Full matrix cycle with no stalls: SIZE*(SIZE+1)/2 load cycles + SIZE*SIZE emit cycles.
- Backpressure: while out_tvalid && !out_tready, out_tdata, out_tlast and e hold stable.
- in_tready returns to 1 on the edge that accepts the out_tlast beat. out_tvalid is 0 in the following cycle.
- Input gaps (in_tvalid = 0) stall the load counters with no side effect.

## Configuration
- SYMMETRIC_MIRROR_EN defined:
  - Each LOAD write also writes M[c][r] = in_tdata when r != c.
  - Output is the full symmetric matrix.
- Undefined:
  - Lower entries stay 0 (cleared at reset, never written).
  - Output is upper-triangular with zero fill.
- Handshake and timing are identical in both builds.

## Test plan
- Basic, SIZE=4, macro off:
  - Stimulus: send packed 1..10 back-to-back with out_tready = 1.
  - Required output: 1,2,3,4, 0,5,6,7, 0,0,8,9, 0,0,0,10.
  - out_tlast only on the 10. First out_tvalid one cycle after the 10 is accepted.
- Mirror, macro on:
  - Stimulus: same input.
  - Required output: 1,2,3,4, 2,5,6,7, 3,6,8,9, 4,7,9,10.
- Backpressure:
  - Stimulus: drop out_tready for 2 cycles while out_tdata = 5 (beat 5).
  - Required: out_tdata stays 5 and out_tvalid stays 1 through the stall. The sequence then resumes with no loss or duplication.
- Input gating:
  - Stimulus: hold in_tvalid = 1 with data 0xDEAD during EMIT.
  - Required: in_tready = 0 throughout EMIT and 0xDEAD is never stored. The next matrix, values 11..20, emits 11,12,13,14, 0,15,16,17, ...
- Reset mid-load:
  - Stimulus: accept 4 elements, pulse rst low for 1 cycle, then send 21..30.
  - Required: the output matrix is built only from 21..30 (21,22,23,24, 0,25,...). No output is produced before the 30 is accepted.
- Back-to-back with input gaps:
  - Stimulus: 3 matrices, with in_tvalid toggling every other cycle.
  - Required: each matrix is emitted complete with exactly one out_tlast per matrix. in_tready reasserts the cycle after each out_tlast handshake.
